// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared state encoding and width helpers for the run controller
package run_ctrl_pkg;

  // Run controller states; encoding is fixed so debug readouts stay stable.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD    = 3'd1,
    RUN     = 3'd2,
    DONE    = 3'd3,
    TIMEOUT = 3'd4
  } run_state_t;

  // Bits needed to count 0..max_cycles run cycles inclusive.
  function automatic int cycles_width(input int max_cycles);
    return $clog2(max_cycles + 1);
  endfunction

  // Bits needed to count 0..depth valid trace entries inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/trace_buffer.sv
// rtl/trace_buffer.sv - circular bus trace with saturating count and oldest-relative registered read
module trace_buffer import run_ctrl_pkg::*; #(
  parameter int WIDTH       = 16,
  parameter int TRACE_DEPTH = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           wr_en,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic [$clog2(TRACE_DEPTH)-1:0] rd_addr,
  output logic [count_width(TRACE_DEPTH)-1:0] count,
  output logic [WIDTH-1:0]               rd_data
);

  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int CW = count_width(TRACE_DEPTH);

  logic [WIDTH-1:0] r_mem [TRACE_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rd_data;
  logic [AW-1:0]    w_phys;
  logic             w_valid;

  // Oldest entry sits count slots behind the write pointer; a full buffer
  // has count[AW-1:0]==0, so the pointer itself is the oldest slot.
  assign w_phys  = r_wr_ptr - r_count[AW-1:0] + rd_addr;
  assign w_valid = ({1'b0, rd_addr} < r_count);

  // Storage writes; contents are never reset, the count decides validity.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Write pointer wraps naturally; count saturates at the depth.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (wr_en) begin
      r_wr_ptr <= r_wr_ptr + AW'(1);
      if (r_count != CW'(TRACE_DEPTH)) begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  // Registered readback; addresses past the valid entries read as zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_valid ? r_mem[w_phys] : '0;
    end
  end

  assign count   = r_count;
  assign rd_data = r_rd_data;

endmodule

// File: rtl/run_controller.sv
// rtl/run_controller.sv - holds the processor in reset, runs it, stops on halt word or timeout
module run_controller import run_ctrl_pkg::*; #(
  parameter int               WIDTH        = 16,
  parameter int               RESET_CYCLES = 2,
  parameter int               MAX_CYCLES   = 300,
  parameter int               TRACE_DEPTH  = 16,
  parameter logic [WIDTH-1:0] HALT_WORD    = {WIDTH{1'b1}}
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [WIDTH-1:0]                     bus,
  input  logic [$clog2(TRACE_DEPTH)-1:0]       trace_addr,
  output logic                                 proc_resetn,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 timeout,
  output logic [cycles_width(MAX_CYCLES)-1:0]  cycles,
  output logic [count_width(TRACE_DEPTH)-1:0]  trace_count,
  output logic [WIDTH-1:0]                     trace_data
);

  localparam int CYW = cycles_width(MAX_CYCLES);
  localparam int HCW = $clog2(RESET_CYCLES + 1);

  run_state_t     r_state;
  run_state_t     w_next;
  logic [HCW-1:0] r_hold_cnt;
  logic [CYW-1:0] r_cycles;
  logic           w_clear;
  logic           w_wr_en;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and state-decoded outputs; halt is tested before the limit so it wins.
  always_comb begin
    w_next      = r_state;
    proc_resetn = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    timeout     = 1'b0;
    w_clear     = 1'b0;
    w_wr_en     = 1'b0;
    case (r_state)
      IDLE, DONE, TIMEOUT: begin
        done    = (r_state == DONE);
        timeout = (r_state == TIMEOUT);
        if (start) begin
          w_next  = HOLD;
          w_clear = 1'b1;
        end
      end
      HOLD: begin
        busy = 1'b1;
        if (r_hold_cnt == HCW'(RESET_CYCLES - 1)) begin
          w_next = RUN;
        end
      end
      RUN: begin
        busy        = 1'b1;
        proc_resetn = 1'b1;
        w_wr_en     = 1'b1;
        if (bus == HALT_WORD) begin
          w_next = DONE;
        end else if (r_cycles == CYW'(MAX_CYCLES - 1)) begin
          w_next = TIMEOUT;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // HOLD length counter and RUN cycle counter, both restarted by an accepted start.
  always_ff @(posedge clock) begin
    if (reset || w_clear) begin
      r_hold_cnt <= '0;
      r_cycles   <= '0;
    end else begin
      if (r_state == HOLD) begin
        r_hold_cnt <= r_hold_cnt + HCW'(1);
      end
      if (r_state == RUN) begin
        r_cycles <= r_cycles + CYW'(1);
      end
    end
  end

  trace_buffer #(
    .WIDTH       (WIDTH),
    .TRACE_DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clock   (clock),
    .reset   (reset),
    .clear   (w_clear),
    .wr_en   (w_wr_en),
    .wr_data (bus),
    .rd_addr (trace_addr),
    .count   (trace_count),
    .rd_data (trace_data)
  );

  assign cycles = r_cycles;

endmodule

// File: doc/run_controller.md
# run_controller

Synthesizable run controller for the 16-bit multicycle processor. It holds the processor in reset for a programmable number of cycles, then releases it and watches the shared bus for a halt word. It stops the run on that halt word or on a cycle-count timeout, and keeps a circular trace of the last bus values for readback. It sits between the system clock/reset and the processor's `resetn` and `bus` ports.

## Interface
- `WIDTH`, 16, bus/data width.
- `RESET_CYCLES`, 2, cycles the processor is held in reset before a run; ≥1.
- `MAX_CYCLES`, 300, run-cycle limit before timeout; ≥1.
- `TRACE_DEPTH`, 16, trace entries; power of 2, ≥2.
- `HALT_WORD`, {WIDTH{1'b1}}, bus value that ends a run.

- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a run; sampled only in IDLE, DONE or TIMEOUT.
- `bus` in WIDTH: processor bus, sampled every RUN cycle.
- `trace_addr` in log2(TRACE_DEPTH): trace index; 0 is the oldest entry.
- `proc_resetn` out 1: active-low reset to the processor.
- `busy` out 1: high in HOLD and RUN.
- `done` out 1: run ended on the halt word.
- `timeout` out 1: run ended on the cycle limit.
- `cycles` out clog2(MAX_CYCLES+1): number of RUN cycles elapsed.
- `trace_count` out clog2(TRACE_DEPTH+1): number of valid entries.
- `trace_data` out WIDTH: trace entry at `trace_addr`.

## Operation
- States:
  - IDLE, HOLD, RUN, DONE, TIMEOUT.
  - `proc_resetn` is 0 in every state except RUN.
- IDLE/DONE/TIMEOUT with `start`=1 → HOLD. The same edge clears `cycles`, `trace_count`, the write pointer, `done` and `timeout`.
- HOLD counts RESET_CYCLES cycles, then → RUN. `start` is ignored in HOLD.
- RUN, on every cycle:
  - `bus` is written to the trace at the write pointer.
  - The write pointer increments and wraps modulo TRACE_DEPTH.
  - `trace_count` increments and saturates at TRACE_DEPTH.
  - `cycles` increments.
  - `start` is ignored.
- Halt: `bus`==HALT_WORD in RUN → DONE, `done`=1. The halt word is itself traced and counted.
- Timeout: RUN cycle number MAX_CYCLES completes without a halt → TIMEOUT, `timeout`=1.
- Halt on cycle MAX_CYCLES: halt wins (`done`=1, `timeout`=0).
- `done` and `timeout` are levels. They hold until the next `start` or `reset`.
- Trace read:
  - Physical index = (wr_ptr − trace_count + trace_addr) mod TRACE_DEPTH.
  - `trace_addr` ≥ `trace_count` → `trace_data`=0.
  - Reads are valid in any state. The trace is retained through DONE/TIMEOUT until the next `start`.
- `reset`, including mid-run: state IDLE, all outputs at reset values, trace contents ignored (`trace_count`=0).

## Timing
- Reset values: `proc_resetn`=0, `busy`=0, `done`=0, `timeout`=0, `cycles`=0, `trace_count`=0, `trace_data`=0.
- `start` high at edge N → HOLD from N+1. `proc_resetn` stays 0 for cycles N+1..N+RESET_CYCLES and goes 1 at edge N+RESET_CYCLES+1.
- Halt sampled at edge M → `done`=1, `busy`=0 and `proc_resetn`=0 visible after edge M.
- `trace_data` is registered: 1-cycle latency from `trace_addr`.
- `cycles` and `trace_count` update on the same edge as the trace write.

## Structure
- Package `run_ctrl_pkg` holds:
  - the state enum (IDLE=0, HOLD=1, RUN=2, DONE=3, TIMEOUT=4; 3-bit);
  - width helper functions for `cycles` and `trace_count`.
- Sub-module `trace_buffer`:
  - parametrised by WIDTH and TRACE_DEPTH;
  - owns the RAM, write pointer, saturating count, and registered oldest-relative read;
  - `clear` and `wr_en` are driven by the FSM.
- FSM, HOLD counter and cycle counter live in `run_controller`.

## Test plan
All scenarios use default parameters.

- Start: `reset`, then `start` at cycle 5 → `proc_resetn`=0 during cycles 6–7, =1 from cycle 8; `busy`=1 from cycle 6.
- Halt: `bus`=0x0000..0x0008 over 9 RUN cycles, then 0xFFFF → `done`=1, `cycles`=10, `trace_count`=10. `trace_addr` 0 → 0x0000, 9 → 0xFFFF, 12 → 0x0000.
- Timeout with wrap: `bus`=k on RUN cycle k (0-based), never 0xFFFF → `timeout`=1, `cycles`=300, `trace_count`=16. `trace_addr` 0 → 284, 15 → 299.
- Simultaneous: 0xFFFF on RUN cycle 300 → `done`=1, `timeout`=0, `cycles`=300.
- Mid-run reset: `reset` at RUN cycle 50 → next cycle all outputs at reset values, state IDLE. A following `start` behaves as in the Start scenario.
- Restart: `start` in DONE → `done`=0, `cycles`=0, `trace_count`=0 the next cycle, HOLD entered. `start` pulses during HOLD/RUN have no effect.
